// File: rtl/add_accum_if.sv
// Handshake bundle for add_accum: start/count command, operand stream in,
// final-sum stream out, plus the busy status flag.
interface add_accum_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 12
);
    logic                 start;
    logic [3:0]           count;
    logic                 in_valid;
    logic [WIDTH-1:0]     in_r;
    logic                 in_cout;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic                 out_ovf;
    logic                 busy;

    // Accumulator side
    modport slave (
        input  start, count, in_valid, in_r, in_cout, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, busy
    );

    // Producer/consumer side
    modport master (
        output start, count, in_valid, in_r, in_cout, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, busy
    );
endinterface

// File: rtl/add_accum.sv
// add_accum: sums a programmed number of adder results {C_out, R} into a
// ACC_WIDTH-bit running total with a sticky overflow flag, then presents
// the total on a valid/ready output until the consumer takes it.
module add_accum #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst,
    add_accum_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           remaining_q, remaining_d;
    logic [ACC_WIDTH-1:0] sum_q, sum_d;
    logic                 ovf_q, ovf_d;

    // One extra bit above the sum captures the carry out of the MSB.
    logic [ACC_WIDTH:0]   op_ext_s;
    logic [ACC_WIDTH:0]   add_s;

    // Zero-extend the operand {C_out, R} and form the widened sum.
    always_comb begin
        op_ext_s            = '0;
        op_ext_s[WIDTH:0]   = {bus.in_cout, bus.in_r};
        add_s               = {1'b0, sum_q} + op_ext_s;
    end

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= 4'd0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next-state logic: start only sampled in IDLE, operands only in ACCUM,
    // and the DONE->IDLE edge cannot also accept a start.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && (bus.count != 4'd0)) begin
                    remaining_d = bus.count;
                    sum_d       = '0;
                    ovf_d       = 1'b0;
                    state_d     = ST_ACCUM;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (bus.in_valid) begin
                    sum_d       = add_s[ACC_WIDTH-1:0];
                    ovf_d       = ovf_q | add_s[ACC_WIDTH];
                    remaining_d = remaining_q - 4'd1;
                    if (remaining_q == 4'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d     = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of registered state, so in_ready never
    // depends on in_valid within the same cycle.
    assign bus.in_ready  = (state_q == ST_ACCUM);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_sum   = sum_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_add_accum.sv
// Directed plus random bench for add_accum with a result scoreboard.
module tb_add_accum;

    localparam int WIDTH     = 8;
    localparam int ACC_WIDTH = 12;
    localparam int MODV      = 1 << ACC_WIDTH;

    logic clk;
    logic rst;

    add_accum_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus ();

    add_accum #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Scoreboard entry: {ovf, sum}
    logic [ACC_WIDTH:0] sb_q[$];

    int m_sum;
    int m_ovf;
    int m_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_run(input int n);
        bus.start = 1'b1;
        bus.count = n[3:0];
        @(negedge clk);
        bus.start = 1'b0;
        m_sum  = 0;
        m_ovf  = 0;
        m_left = n;
        chk("start_busy", {31'd0, bus.busy}, 32'd1);
        chk("start_in_ready", {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic send_op(input logic c, input logic [7:0] r);
        int tmp;
        int waited;
        bus.in_valid = 1'b1;
        bus.in_cout  = c;
        bus.in_r     = r;
        waited = 0;
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
        end else begin
            @(negedge clk);
            tmp    = m_sum + ({23'd0, c, r});
            if (tmp >= MODV) m_ovf = 1;
            m_sum  = tmp % MODV;
            m_left = m_left - 1;
            if (m_left == 0) begin
                sb_q.push_back({m_ovf[0], m_sum[ACC_WIDTH-1:0]});
                chk("latency_out_valid", {31'd0, bus.out_valid}, 32'd1);
            end else begin
                chk("live_sum", {20'd0, bus.out_sum}, m_sum);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(input int hold);
        logic [ACC_WIDTH:0] e;
        int waited;
        waited = 0;
        while (!bus.out_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("out_valid_wait", {31'd0, bus.out_valid}, 32'd1);
        if (sb_q.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
        end else if (bus.out_valid) begin
            e = sb_q.pop_front();
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                chk("hold_sum", {20'd0, bus.out_sum}, {20'd0, e[ACC_WIDTH-1:0]});
            end
            chk("out_sum", {20'd0, bus.out_sum}, {20'd0, e[ACC_WIDTH-1:0]});
            chk("out_ovf", {31'd0, bus.out_ovf}, {31'd0, e[ACC_WIDTH]});
            bus.out_ready = 1'b1;
            bus.start     = 1'b1;
            bus.count     = 4'd3;
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.start     = 1'b0;
            chk("valid_fall", {31'd0, bus.out_valid}, 32'd0);
            chk("no_start_on_handshake", {31'd0, bus.busy}, 32'd0);
            chk("idle_retains_sum", {20'd0, bus.out_sum}, {20'd0, e[ACC_WIDTH-1:0]});
        end
    endtask

    initial begin
        int n;
        bus.start = 1'b0;  bus.count = 4'd0;  bus.in_valid = 1'b0;
        bus.in_r  = 8'd0;  bus.in_cout = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_sum", {20'd0, bus.out_sum}, 32'd0);
        chk("rst_ovf", {31'd0, bus.out_ovf}, 32'd0);
        rst = 1'b0;

        // count=3, back-to-back operands -> 655, no overflow
        start_run(3);
        send_op(1'b0, 8'd100);
        send_op(1'b1, 8'd44);
        send_op(1'b0, 8'd255);
        collect(0);

        // count=15 of 511 -> 3569 with overflow
        start_run(15);
        for (int i = 0; i < 15; i++) send_op(1'b1, 8'd255);
        collect(0);

        // gaps between operands, consumer stalls 4 cycles
        start_run(2);
        send_op(1'b0, 8'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("gap_sum", {20'd0, bus.out_sum}, 32'd7);
            chk("gap_ready", {31'd0, bus.in_ready}, 32'd1);
        end
        send_op(1'b0, 8'd9);
        collect(4);

        // start with count=0 is ignored
        bus.start = 1'b1; bus.count = 4'd0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("cnt0_busy", {31'd0, bus.busy}, 32'd0);
        chk("cnt0_in_ready", {31'd0, bus.in_ready}, 32'd0);

        // start during ACCUM has no effect
        start_run(2);
        send_op(1'b0, 8'd5);
        bus.start = 1'b1; bus.count = 4'd9;
        @(negedge clk);
        bus.start = 1'b0;
        chk("accum_start_sum", {20'd0, bus.out_sum}, 32'd5);
        send_op(1'b0, 8'd6);
        collect(0);

        // reset mid-run aborts
        start_run(5);
        send_op(1'b1, 8'd10);
        send_op(1'b1, 8'd20);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_sum", {20'd0, bus.out_sum}, 32'd0);
        chk("abort_ovf", {31'd0, bus.out_ovf}, 32'd0);
        chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start_run(1);
        send_op(1'b0, 8'd42);
        collect(0);
        repeat (3) begin
            @(negedge clk);
            chk("no_stray_valid", {31'd0, bus.out_valid}, 32'd0);
        end

        // random runs against the model
        for (int run = 0; run < 20; run++) begin
            n = $urandom_range(15, 1);
            start_run(n);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(1, 0) == 1) @(negedge clk);
                send_op(1'($urandom), 8'($urandom));
            end
            collect($urandom_range(2, 0));
        end

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/add_accum.md
ADD_ACCUM -- requirements
Module: add_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 8, width of the adder result R consumed per operand.
REQ-002 SHALL have parameter ACC_WIDTH, default 12, width of the running sum.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin a new accumulation; sampled only in IDLE.
REQ-006 SHALL have port count  input  4  number of operands to accumulate, 1..15; sampled with start.
REQ-007 SHALL have port in_valid  input  1  upstream operand valid.
REQ-008 SHALL have port in_r  input  WIDTH  adder result R.
REQ-009 SHALL have port in_cout  input  1  adder carry-out C_out.
REQ-010 SHALL have port in_ready  output  1  block accepts an operand this cycle.
REQ-011 SHALL have port out_valid  output  1  final sum available.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the sum.
REQ-013 SHALL have port out_sum  output  ACC_WIDTH  accumulated sum.
REQ-014 SHALL have port out_ovf  output  1  sticky overflow for the current accumulation.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, ACCUM, DONE.
REQ-017 Operand value SHALL be the zero-extended (WIDTH+1)-bit concatenation {in_cout, in_r}, giving a range of 0..511 at the default WIDTH.
REQ-018 In IDLE with start=1 and count!=0, the block SHALL load remaining=count, clear the sum and out_ovf, and enter ACCUM on the next edge.
REQ-019 In IDLE with start=1 and count=0, the block SHALL ignore the request and remain in IDLE.
REQ-020 start SHALL be ignored in ACCUM and DONE.
REQ-021 in_ready SHALL be 1 only in ACCUM; it is a registered-state decode and SHALL NOT depend combinationally on in_valid.
REQ-022 An operand SHALL be accepted on any edge where in_valid=1 and in_ready=1; on acceptance the sum becomes (sum + operand) mod 2^ACC_WIDTH and remaining decrements by 1.
REQ-023 out_ovf SHALL be set when any accepted addition carries out of bit ACC_WIDTH-1, and SHALL remain set until the next accepted start or reset.
REQ-024 On accepting the operand with remaining=1, the FSM SHALL enter DONE; out_valid rises the cycle after the last accepted operand (latency 1).
REQ-025 While in_valid=0 in ACCUM, the FSM SHALL hold all state; there is no timeout.
REQ-026 In DONE, out_valid=1, and out_sum and out_ovf SHALL be held stable until the handshake completes.
REQ-027 In DONE with out_ready=1, the FSM SHALL return to IDLE on that edge; out_valid falls the next cycle.
REQ-028 The block SHALL NOT accept a start in the same cycle as the DONE->IDLE handshake; a new start is accepted no earlier than the following cycle.
REQ-029 out_sum SHALL show the live running sum in ACCUM and the final sum in DONE; in IDLE it SHALL retain the last final sum.

Reset
REQ-030 On rst=1, asynchronously and regardless of state, the block SHALL enter IDLE and clear the sum, remaining and out_ovf to 0; in_ready=0, out_valid=0, busy=0.
REQ-031 A reset asserted during ACCUM or DONE SHALL abort the accumulation; no out_valid SHALL follow for the aborted run.
REQ-032 After rst deasserts, the block SHALL be ready to accept start on the first rising edge.

Verification
REQ-033 count=3, operands {0,100}, {1,44}, {0,255} back-to-back -> out_valid one cycle after the third operand, out_sum=655, out_ovf=0.
REQ-034 count=15, each operand {1,255} (value 511) -> out_sum = 7665 mod 4096 = 3569, out_ovf=1.
REQ-035 count=2 with in_valid gaps of 3 idle cycles between operands 7 and 9 -> state held during the gaps, out_sum=16; out_ready held 0 for 4 cycles -> out_valid and out_sum stable throughout.
REQ-036 start with count=0 -> busy stays 0 and in_ready stays 0; start asserted during ACCUM -> no effect on remaining or sum.
REQ-037 rst pulsed mid-ACCUM after 2 of 5 operands -> immediate IDLE, out_sum=0, out_ovf=0, no out_valid; a fresh count=1 run with operand 42 -> out_sum=42.
REQ-038 Random stream (20 runs, $random operands and count) checked against a reference model of the mod-2^ACC_WIDTH sum and the sticky overflow.
